// File: rtl/seven_seg_scanner.sv
// Multiplexed hex seven-segment driver with a double-buffered display image that commits only at frame boundaries.
// Optional leading-zero suppression (extra lz_en input) is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 131072
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef LEADING_ZERO_BLANK_EN
   input  logic                    lz_en,
`endif
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [6:0]              led,
   output logic                    dp,
   output logic                    pending
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           presc_q, presc_d;
   logic [IW-1:0]           index_q, index_d;
   logic [4*NUM_DIGITS-1:0] activeDigits_q, activeDigits_d;
   logic [NUM_DIGITS-1:0]   activeBlank_q, activeBlank_d;
   logic [NUM_DIGITS-1:0]   activeDp_q, activeDp_d;
   logic [4*NUM_DIGITS-1:0] shadowDigits_q, shadowDigits_d;
   logic [NUM_DIGITS-1:0]   shadowBlank_q, shadowBlank_d;
   logic [NUM_DIGITS-1:0]   shadowDp_q, shadowDp_d;
   logic                    pending_q, pending_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              led_q, led_d;
   logic                    dp_q, dp_d;

   logic                    digitTick;
   logic                    frameEnd;
   logic [3:0]              curNibble;
   logic                    curBlank;
   logic                    curDp;
   logic                    lzBlank;

   function automatic logic [6:0] glyph(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

   // Scan timing plus buffer management: a load always lands in the shadow,
   // even on the boundary edge, so the commit there takes the older image.
   always_comb begin
      digitTick = (presc_q == PRESC_LAST);
      frameEnd  = digitTick && (index_q == INDEX_LAST);

      presc_d = digitTick ? '0 : presc_q + 1'b1;
      index_d = index_q;
      if (digitTick) begin
         index_d = (index_q == INDEX_LAST) ? '0 : index_q + 1'b1;
      end

      activeDigits_d = activeDigits_q;
      activeBlank_d  = activeBlank_q;
      activeDp_d     = activeDp_q;
      pending_d      = pending_q;
      if (frameEnd && pending_q) begin
         activeDigits_d = shadowDigits_q;
         activeBlank_d  = shadowBlank_q;
         activeDp_d     = shadowDp_q;
         pending_d      = 1'b0;
      end

      shadowDigits_d = shadowDigits_q;
      shadowBlank_d  = shadowBlank_q;
      shadowDp_d     = shadowDp_q;
      if (load) begin
         shadowDigits_d = digits_in;
         shadowBlank_d  = blank_in;
         shadowDp_d     = dp_in;
         pending_d      = 1'b1;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A zero digit is suppressed only if no unblanked non-zero digit sits at or above it.
   logic [NUM_DIGITS-1:0] lzMask;
   always_comb begin
      logic seenSignificant;
      seenSignificant = 1'b0;
      lzMask          = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if ((activeDigits_q[4*k +: 4] != 4'h0) && !activeBlank_q[k]) begin
            seenSignificant = 1'b1;
         end
         if (!seenSignificant && (activeDigits_q[4*k +: 4] == 4'h0)) begin
            lzMask[k] = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      curNibble = 4'h0;
      curBlank  = 1'b0;
      curDp     = 1'b0;
      an_d      = '1;
      lzBlank   = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (IW'(k) == index_q) begin
            curNibble = activeDigits_q[4*k +: 4];
            curBlank  = activeBlank_q[k];
            curDp     = activeDp_q[k];
            an_d[k]   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            lzBlank   = lz_en && lzMask[k];
`endif
         end
      end

      if (curBlank || lzBlank) begin
         led_d = 7'b1111111;
         dp_d  = 1'b1;
      end else begin
         led_d = glyph(curNibble);
         dp_d  = ~curDp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q        <= '0;
         index_q        <= '0;
         activeDigits_q <= '0;
         activeBlank_q  <= '0;
         activeDp_q     <= '0;
         shadowDigits_q <= '0;
         shadowBlank_q  <= '0;
         shadowDp_q     <= '0;
         pending_q      <= 1'b0;
         an_q           <= '1;
         led_q          <= 7'b1111111;
         dp_q           <= 1'b1;
      end else begin
         presc_q        <= presc_d;
         index_q        <= index_d;
         activeDigits_q <= activeDigits_d;
         activeBlank_q  <= activeBlank_d;
         activeDp_q     <= activeDp_d;
         shadowDigits_q <= shadowDigits_d;
         shadowBlank_q  <= shadowBlank_d;
         shadowDp_q     <= shadowDp_d;
         pending_q      <= pending_d;
         an_q           <= an_d;
         led_q          <= led_d;
         dp_q           <= dp_d;
      end
   end

   assign AN      = an_q;
   assign led     = led_q;
   assign dp      = dp_q;
   assign pending = pending_q;

endmodule
